// File: rtl/nova_bus_pkg.sv
// Lane numbering and bus widths shared by the 1:8 demux slices and the gather mux.
package nova_bus_pkg;
  localparam int BUS_W     = 16;
  localparam int NSRC      = 8;
  localparam int SELW      = 3;
  localparam int SEL_BUS_W = BUS_W * SELW;

  localparam logic [SELW-1:0] LANE0 = 3'd0;
  localparam logic [SELW-1:0] LANE1 = 3'd1;
  localparam logic [SELW-1:0] LANE2 = 3'd2;
  localparam logic [SELW-1:0] LANE3 = 3'd3;
  localparam logic [SELW-1:0] LANE4 = 3'd4;
  localparam logic [SELW-1:0] LANE5 = 3'd5;
  localparam logic [SELW-1:0] LANE6 = 3'd6;
  localparam logic [SELW-1:0] LANE7 = 3'd7;
endpackage

// File: rtl/mux_8_1.sv
// One-bit 8:1 select; code k picks input k, matching the demux slice lane numbering.
module mux_8_1
  import nova_bus_pkg::*;
(
  input  logic [NSRC-1:0] d,
  input  logic [SELW-1:0] sel,
  output logic            y
);
  always_comb begin
    y = 1'b0;
    case (sel)
      LANE0: y = d[0];
      LANE1: y = d[1];
      LANE2: y = d[2];
      LANE3: y = d[3];
      LANE4: y = d[4];
      LANE5: y = d[5];
      LANE6: y = d[6];
      LANE7: y = d[7];
      default: y = 1'b0;
    endcase
  end
endmodule

// File: rtl/mux_16_gather.sv
// Per-bit gather across eight source lanes, feeding a small FIFO with a
// registered head (dout/out_valid) toward the ALU/writeback input.
module mux_16_gather
  import nova_bus_pkg::*;
#(
  parameter int WIDTH = BUS_W,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH*SELW-1:0] sel,
  input  logic [WIDTH-1:0]      din7,
  input  logic [WIDTH-1:0]      din6,
  input  logic [WIDTH-1:0]      din5,
  input  logic [WIDTH-1:0]      din4,
  input  logic [WIDTH-1:0]      din3,
  input  logic [WIDTH-1:0]      din2,
  input  logic [WIDTH-1:0]      din1,
  input  logic [WIDTH-1:0]      din0,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      dout,
  output logic [2:0]            count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NSRC-1:0][WIDTH-1:0]  src;
  logic [WIDTH-1:0]            g;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr, rd_nxt;
  logic [2:0]                  count_nxt;
  logic                        push, pop;

  assign src = {din7, din6, din5, din4, din3, din2, din1, din0};

  // Transpose so each bit lane sees bit n of all eight sources.
  for (genvar n = 0; n < WIDTH; n++) begin : g_lane
    logic [NSRC-1:0] lane;
    for (genvar k = 0; k < NSRC; k++) begin : g_src
      assign lane[k] = src[k][n];
    end
    mux_8_1 u_mux (.d(lane), .sel(sel[SELW*n +: SELW]), .y(g[n]));
  end

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // in_ready depends on registered count only, never on out_ready.
  assign in_ready = (count < 3'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign rd_nxt   = pop ? inc(rd_ptr) : rd_ptr;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 3'd1;
      2'b01:   count_nxt = count - 3'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= g;
        wr_ptr      <= inc(wr_ptr);
      end
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      out_valid <= (count_nxt != 3'd0);
      // New word lands straight on dout when it becomes the head this cycle.
      if (push && (count == {2'b00, pop}))
        dout <= g;
      else if (pop && (count_nxt != 3'd0))
        dout <= mem[rd_nxt];
    end
  end
endmodule
